// File: rtl/miner_link_ctrl_if.sv
// UART-side handshake bundle for miner_link_ctrl: receive strobe/byte in,
// transmit strobe/byte out, plus transmitter busy/done status.
interface miner_link_ctrl_if;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       tx_active;
    logic       tx_done;
    logic       tx_dv;
    logic [7:0] tx_byte;

    modport master (
        input  rx_dv, rx_byte, tx_active, tx_done,
        output tx_dv, tx_byte
    );

    modport slave (
        output rx_dv, rx_byte, tx_active, tx_done,
        input  tx_dv, tx_byte
    );
endinterface

// File: rtl/miner_link_ctrl.sv
// Mining link controller: assembles a block header from UART bytes, runs the hash
// core, and periodically reports best_nonce over UART. Optional MINER_LINK_TIMEOUT_EN.
module miner_link_ctrl #(
    parameter int HDR_BYTES      = 76,
    parameter int REPORT_TICKS   = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_i,
    miner_link_ctrl_if.master      link,
    input  logic                   second_tick,
    input  logic [31:0]            best_nonce,
    output logic                   hash_enable,
    output logic                   hash_clear,
    output logic [8*HDR_BYTES-1:0] block_info,
    output logic [1:0]             state_o
);

    localparam int CNT_W = $clog2(HDR_BYTES + 1);

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        CLEAR = 2'd1,
        HASH  = 2'd2,
        SEND  = 2'd3
    } state_t;

    if (HDR_BYTES < 2) begin : g_bad_hdr
        $error("miner_link_ctrl: HDR_BYTES must be at least 2");
    end
    if (REPORT_TICKS < 1 || REPORT_TICKS > 255) begin : g_bad_ticks
        $error("miner_link_ctrl: REPORT_TICKS must be in 1..255");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("miner_link_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    state_t                   state_reg;
    logic [CNT_W-1:0]         byte_cnt_reg;
    logic [7:0]               tick_cnt_reg;
    logic [2:0]               tx_cnt_reg;
    logic                     tx_wait_reg;
    logic [31:0]              snapshot_reg;
    logic                     tx_dv_reg;
    logic [7:0]               tx_byte_reg;
    logic                     hash_enable_reg;
    logic                     hash_clear_reg;
    logic [8*HDR_BYTES-1:0]   block_info_reg;

    logic [8*HDR_BYTES-1:0]   hdr_shifted;
    logic [7:0]               snap_byte [4];
    logic                     last_byte;
    logic                     last_tick;
    logic                     can_issue;
    logic                     timeout_hit;

    assign hdr_shifted = {block_info_reg[8*HDR_BYTES-9:0], link.rx_byte};
    assign last_byte   = (byte_cnt_reg == CNT_W'(HDR_BYTES - 1));
    assign last_tick   = (tick_cnt_reg == 8'(REPORT_TICKS - 1));

    // Snapshot bytes in transmit order, most significant first
    for (genvar gi = 0; gi < 4; gi++) begin : g_snap
        assign snap_byte[gi] = snapshot_reg[31-8*gi -: 8];
    end

    // Next byte may go once the previous one is acknowledged and the UART is idle
    assign can_issue = (!tx_wait_reg || link.tx_done) && !link.tx_active
                       && (tx_cnt_reg != 3'd4);

`ifdef MINER_LINK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] timeout_cnt_reg;

    assign timeout_hit = (state_reg == RECV) && (byte_cnt_reg != '0) && !link.rx_dv
                         && (timeout_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_i || state_reg != RECV || byte_cnt_reg == '0 || link.rx_dv || timeout_hit) begin
            timeout_cnt_reg <= '0;
        end else begin
            timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_i) begin
            state_reg       <= RECV;
            byte_cnt_reg    <= '0;
            tick_cnt_reg    <= '0;
            tx_cnt_reg      <= '0;
            tx_wait_reg     <= 1'b0;
            snapshot_reg    <= '0;
            tx_dv_reg       <= 1'b0;
            tx_byte_reg     <= '0;
            hash_enable_reg <= 1'b0;
            hash_clear_reg  <= 1'b0;
            block_info_reg  <= '0;
        end else begin
            tx_dv_reg      <= 1'b0;
            hash_clear_reg <= 1'b0;
            case (state_reg)
                RECV: begin
                    hash_enable_reg <= 1'b0;
                    if (link.rx_dv) begin
                        block_info_reg <= hdr_shifted;
                        if (last_byte) begin
                            byte_cnt_reg   <= '0;
                            state_reg      <= CLEAR;
                            hash_clear_reg <= 1'b1;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
                        end
                    end else if (timeout_hit) begin
                        byte_cnt_reg <= '0;
                    end
                end
                CLEAR: begin
                    state_reg       <= HASH;
                    hash_enable_reg <= 1'b1;
                    tick_cnt_reg    <= '0;
                end
                HASH: begin
                    // A new header byte takes priority over a coincident tick
                    if (link.rx_dv) begin
                        block_info_reg  <= hdr_shifted;
                        byte_cnt_reg    <= CNT_W'(1);
                        tick_cnt_reg    <= '0;
                        state_reg       <= RECV;
                        hash_enable_reg <= 1'b0;
                    end else if (second_tick) begin
                        if (last_tick) begin
                            tick_cnt_reg <= '0;
                            snapshot_reg <= best_nonce;
                            state_reg    <= SEND;
                            // Launch byte 1 so tx_dv is high on the first SEND cycle
                            if (!link.tx_active) begin
                                tx_dv_reg   <= 1'b1;
                                tx_byte_reg <= best_nonce[31:24];
                                tx_cnt_reg  <= 3'd1;
                                tx_wait_reg <= 1'b1;
                            end else begin
                                tx_cnt_reg  <= 3'd0;
                                tx_wait_reg <= 1'b0;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 8'd1;
                        end
                    end
                end
                SEND: begin
                    if (link.tx_done && tx_wait_reg && tx_cnt_reg == 3'd4) begin
                        state_reg    <= HASH;
                        tx_cnt_reg   <= '0;
                        tx_wait_reg  <= 1'b0;
                        tick_cnt_reg <= '0;
                    end else if (can_issue) begin
                        tx_dv_reg   <= 1'b1;
                        tx_byte_reg <= snap_byte[tx_cnt_reg[1:0]];
                        tx_cnt_reg  <= tx_cnt_reg + 3'd1;
                        tx_wait_reg <= 1'b1;
                    end else if (link.tx_done) begin
                        tx_wait_reg <= 1'b0;
                    end
                end
                default: state_reg <= RECV;
            endcase
        end
    end

    assign link.tx_dv   = tx_dv_reg;
    assign link.tx_byte = tx_byte_reg;
    assign hash_enable  = hash_enable_reg;
    assign hash_clear   = hash_clear_reg;
    assign block_info   = block_info_reg;
    assign state_o      = state_reg;

endmodule

// File: doc/miner_link_ctrl.md
MINER_LINK_CTRL -- requirements
Module: miner_link_ctrl

Interface
REQ-001 SHALL have parameter HDR_BYTES, default 76: header length in bytes.
REQ-002 SHALL have parameter REPORT_TICKS, default 1: second_tick pulses per nonce report, range 1..255.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000: inter-byte timeout, used only under MINER_LINK_TIMEOUT_EN.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port rx_dv, input, 1: one-cycle pulse, rx_byte valid.
REQ-007 SHALL have port rx_byte, input, 8: received UART byte.
REQ-008 SHALL have port tx_active, input, 1: UART transmitter busy.
REQ-009 SHALL have port tx_done, input, 1: one-cycle pulse, byte transmitted.
REQ-010 SHALL have port tx_dv, output, 1: one-cycle pulse, start transmitting tx_byte.
REQ-011 SHALL have port tx_byte, output, 8: byte to transmit.
REQ-012 SHALL have port second_tick, input, 1: one-cycle pulse from timer.
REQ-013 SHALL have port best_nonce, input, 32: current best nonce from hash core.
REQ-014 SHALL have port hash_enable, output, 1: hash core run enable.
REQ-015 SHALL have port hash_clear, output, 1: one-cycle pulse clearing hash core best-result state.
REQ-016 SHALL have port block_info, output, 8*HDR_BYTES: assembled header.
REQ-017 SHALL have port state_o, output, 2: RECV=0, CLEAR=1, HASH=2, SEND=3.

Function
REQ-018 In RECV, each rx_dv SHALL update block_info to {block_info[8*HDR_BYTES-9:0], rx_byte} on the same edge and increment the byte count; the first byte received ends up MSB.
REQ-019 The rx_dv carrying byte HDR_BYTES SHALL be stored, clear the count to 0, and move to CLEAR on the same edge; no extra byte or terminator is consumed.
REQ-020 CLEAR SHALL last exactly one cycle with hash_clear=1 and hash_enable=0, then go to HASH.
REQ-021 In HASH, hash_enable SHALL be 1; each second_tick SHALL increment the tick count.
REQ-022 On the tick that reaches REPORT_TICKS, the block SHALL latch best_nonce into a snapshot register, clear the tick count, and go to SEND on the same edge.
REQ-023 In HASH, rx_dv SHALL abort hashing: the byte is stored as header byte 1 (count=1) and the state goes to RECV; when rx_dv and second_tick coincide, rx_dv wins and the tick is discarded.
REQ-024 In SEND, hash_enable SHALL stay 1; the 4 snapshot bytes SHALL be sent MSB first, each as a single tx_dv pulse with tx_byte stable from that cycle until the next tx_dv.
REQ-025 In SEND, tx_dv for the next byte SHALL be issued only when tx_active=0 and the previous byte's tx_done has been seen; the first byte is issued on the first cycle in SEND with tx_active=0.
REQ-026 The tx_done of byte 4 SHALL return the state to HASH on the next edge, with the tick count at 0.
REQ-027 In SEND, rx_dv and second_tick SHALL be ignored (dropped, not counted).
REQ-028 In RECV and CLEAR, second_tick SHALL be ignored and hash_enable SHALL be 0.

Reset
REQ-029 When rst_i=0 at a rising clk edge, the state SHALL become RECV; byte, tick and tx counters SHALL become 0; block_info and the snapshot SHALL become 0; tx_dv, hash_enable and hash_clear SHALL become 0; tx_byte SHALL become 0.
REQ-030 A reset during SEND SHALL abandon the remaining bytes with no further tx_dv; the byte already handed to the UART is not recalled.

Configuration
REQ-031 With MINER_LINK_TIMEOUT_EN defined, a partial header (count 1..HDR_BYTES-1) with no rx_dv for TIMEOUT_CYCLES consecutive cycles SHALL reset the count to 0, leaving block_info unchanged.
REQ-032 Without MINER_LINK_TIMEOUT_EN, no timeout counter SHALL exist, and a partial header SHALL wait indefinitely.

Verification
REQ-033 Send 76 bytes 0x00..0x4B -> block_info[607:600]=0x00, block_info[7:0]=0x4B, one cycle of hash_clear, then HASH with hash_enable=1.
REQ-034 In HASH with best_nonce=0xDEADBEEF, REPORT_TICKS=1, pulse second_tick -> tx bytes DE, AD, BE, EF in order, each tx_dv 1 cycle, and return to HASH after the 4th tx_done.
REQ-035 In HASH, assert rx_dv(0x55) and second_tick on the same cycle -> state RECV, count=1, no transmission.
REQ-036 Pull rst_i low after the 2nd tx_dv in SEND -> no further tx_dv, state RECV, all outputs 0.
REQ-037 With MINER_LINK_TIMEOUT_EN and TIMEOUT_CYCLES=100, send 10 bytes, idle 100 cycles, then send 76 bytes -> header equals the last 76 bytes and CLEAR occurs exactly once.
